// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: definitions shared by the Tiny-CPU register bank and its
// scan controller.
//   scan_state_e  - scan controller state encoding (IDLE/SCAN/DONE)
//   REG_COUNT     - number of registers feeding the byte mux
//   SEL_W         - width of the mux select
//   HOLD_W        - width of the scan hold counter
//   SEL_LAST      - last select value visited by a scan
//   addr_onehot() - register-address to one-hot write-enable decode
package tiny_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam int REG_COUNT = 8;
  localparam int SEL_W     = 3;
  localparam int HOLD_W    = 8;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(REG_COUNT - 1);

  function automatic logic [REG_COUNT-1:0] addr_onehot(input logic [SEL_W-1:0] addr);
    return REG_COUNT'(1) << addr;
  endfunction

endpackage

// File: rtl/reg_bank8_scan_ctrl.sv
// reg_bank8_scan_ctrl: select register, hold counter and scan FSM for the
// register bank.
//   clk, rst     - clock, asynchronous active-high reset
//   sel_load     - load rd_sel into sel (IDLE only)
//   rd_sel       - direct select value
//   scan_start   - begin a 0..7 select scan (IDLE only, beats sel_load)
//   sel          - registered mux select
//   wr_ready     - high in IDLE; gates the write port of the top level
//   scanning     - high in SCAN
//   scan_done    - high for the single DONE cycle that ends a scan
module reg_bank8_scan_ctrl
  import tiny_cpu_pkg::*;
#(
  parameter int SCAN_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             scan_start,
  output logic [SEL_W-1:0] sel,
  output logic             wr_ready,
  output logic             scanning,
  output logic             scan_done
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);

  scan_state_e       state, state_n;
  logic [SEL_W-1:0]  sel_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_n    = SCAN;
          sel_n      = '0;
          hold_cnt_n = '0;
        end else if (sel_load) begin
          sel_n = rd_sel;
        end
      end
      SCAN: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_n = '0;
          // Sel parks on the last register; the scan ends instead of wrapping.
          if (sel == SEL_LAST) begin
            state_n = DONE;
          end else begin
            sel_n = sel + SEL_W'(1);
          end
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are pure state decodes, so they follow reset immediately
  // and never depend combinationally on inputs.
  always_comb begin
    wr_ready  = (state == IDLE);
    scanning  = (state == SCAN);
    scan_done = (state == DONE);
  end

endmodule

// File: rtl/reg_bank8.sv
// reg_bank8: eight-entry register bank driving the Tiny-CPU 8-to-1 byte mux.
//   Clk, Reset        - clock, asynchronous active-high reset
//   WrEn/WrAddr/WrData- write port, accepted when WrEn && WrReady at an edge
//   WrReady           - write port ready (IDLE only)
//   RdSel, SelLoad    - direct load of the mux select
//   ScanStart         - step Sel through 0..7, SCAN_HOLD cycles per value
//   A..H              - register contents, to mux data inputs
//   Sel               - registered mux select
//   Scanning/ScanDone - scan in progress / one-cycle end-of-scan pulse
module reg_bank8
  import tiny_cpu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SCAN_HOLD = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [2:0]       WrAddr,
  input  logic [WIDTH-1:0] WrData,
  output logic             WrReady,
  input  logic [2:0]       RdSel,
  input  logic             SelLoad,
  input  logic             ScanStart,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [2:0]       Sel,
  output logic             Scanning,
  output logic             ScanDone
);

  logic [WIDTH-1:0]     regs [REG_COUNT];
  logic [REG_COUNT-1:0] wr_sel;
  logic                 wr_fire;

  reg_bank8_scan_ctrl #(
    .SCAN_HOLD (SCAN_HOLD)
  ) u_scan_ctrl (
    .clk        (Clk),
    .rst        (Reset),
    .sel_load   (SelLoad),
    .rd_sel     (RdSel),
    .scan_start (ScanStart),
    .sel        (Sel),
    .wr_ready   (WrReady),
    .scanning   (Scanning),
    .scan_done  (ScanDone)
  );

  // WrReady is high only in IDLE, so a write coinciding with ScanStart
  // still lands, while writes during SCAN/DONE are dropped.
  assign wr_fire = WrEn && WrReady;
  assign wr_sel  = wr_fire ? addr_onehot(WrAddr) : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_sel[i]) regs[i] <= WrData;
      end
    end
  end

  assign A = regs[0];
  assign B = regs[1];
  assign C = regs[2];
  assign D = regs[3];
  assign E = regs[4];
  assign F = regs[5];
  assign G = regs[6];
  assign H = regs[7];

endmodule
